// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU control codes, operand selects
// and the registered control bundle handed from decode to execute.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU control is {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_SHAMT = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu_ctrl;
        op1_sel_e    op1_sel;
        op2_sel_e    op2_sel;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic [2:0]  mem_size;
        logic        illegal;
    } decode_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extractor; shift-immediates yield the bare shamt
// so the funct7 bits never leak into the operand.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:     imm = {instr[31:12], 12'b0};
            IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_SHAMT: imm = {27'b0, instr[24:20]};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage with valid/ready handshake and flush.
// Define DECODE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module rv_decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [3:0]            alu_ctrl,
    output logic [1:0]            op1_sel,
    output logic                  op2_sel,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    output logic [4:0]            rd_addr,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch,
    output logic                  jump,
    output logic                  jalr,
    output logic [2:0]            mem_size,
    output logic                  illegal
);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    imm_fmt_e       fmt;
    logic [31:0]    gen_imm;
    decode_bundle_t dec;
    decode_bundle_t q;
    logic           q_valid;
    logic           take;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        fmt = IMM_NONE;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) fmt = IMM_SHAMT;
                else                                        fmt = IMM_I;
            end
            OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:          fmt = IMM_S;
            OPC_BRANCH:         fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: fmt = IMM_U;
            OPC_JAL:            fmt = IMM_J;
            default:            fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (gen_imm)
    );

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.rs1_addr = in_instr[19:15];
        dec.rs2_addr = in_instr[24:20];
        dec.rd_addr  = in_instr[11:7];
        dec.alu_ctrl = ALU_ADD;
        dec.op1_sel  = OP1_RS1;
        dec.op2_sel  = OP2_IMM;
        dec.imm      = gen_imm;
        case (opcode)
            OPC_OP: begin
                dec.op2_sel   = OP2_RS2;
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = {funct7[5], funct3};
                if (funct7 != 7'h00 && funct7 != 7'h20)
                    dec.illegal = 1'b1;
                else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
                    dec.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_ctrl  = {1'b0, funct3};
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    dec.illegal = 1'b1;
                if (funct3 == 3'b101) begin
                    dec.alu_ctrl = {funct7[5], funct3};
                    if (funct7 != 7'h00 && funct7 != 7'h20)
                        dec.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.mem_size  = funct3;
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.mem_size  = funct3;
            end
            OPC_BRANCH: begin
                dec.op2_sel  = OP2_RS2;
                dec.branch   = 1'b1;
                dec.alu_ctrl = {1'b0, funct3};
            end
            OPC_LUI: begin
                dec.op1_sel   = OP1_ZERO;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op1_sel   = OP1_PC;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.op1_sel   = OP1_PC;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal bundle is made inert: only pc and register fields survive
        if (dec.illegal) begin
            dec.alu_ctrl  = ALU_ADD;
            dec.op1_sel   = OP1_RS1;
            dec.op2_sel   = OP2_RS2;
            dec.imm       = '0;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.jalr      = 1'b0;
            dec.mem_size  = 3'b000;
        end
    end

`ifdef DECODE_SKID_EN
    decode_bundle_t skid_q;
    logic           skid_valid;
    logic           ready_q;

    assign in_ready = ready_q;
    assign take     = in_valid && ready_q;

    // The skid entry is older than any new arrival, so it always drains first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            q_valid    <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (flush) begin
            q_valid    <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (!q_valid || out_ready) begin
            if (skid_valid) begin
                q          <= skid_q;
                q_valid    <= 1'b1;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else begin
                q_valid <= take;
                ready_q <= 1'b1;
                if (take) q <= dec;
            end
        end else if (take) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
        end
    end
`else
    assign in_ready = !q_valid || out_ready;
    assign take     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            if (flush)          q_valid <= 1'b0;
            else if (take)      q_valid <= 1'b1;
            else if (out_ready) q_valid <= 1'b0;
            if (take && !flush) q <= dec;
        end
    end
`endif

    assign out_valid = q_valid;
    assign out_pc    = q.pc;
    assign alu_ctrl  = q.alu_ctrl;
    assign op1_sel   = q.op1_sel;
    assign op2_sel   = q.op2_sel;
    assign imm       = q.imm;
    assign rs1_addr  = q.rs1_addr;
    assign rs2_addr  = q.rs2_addr;
    assign rd_addr   = q.rd_addr;
    assign reg_write = q.reg_write;
    assign mem_read  = q.mem_read;
    assign mem_write = q.mem_write;
    assign branch    = q.branch;
    assign jump      = q.jump;
    assign jalr      = q.jalr;
    assign mem_size  = q.mem_size;
    assign illegal   = q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage; expected bundles are queued on
// acceptance and compared when the stage presents them.
module tb_rv_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [1:0]  op1;
        logic        op2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [5:0]  flags;
        logic [2:0]  msz;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [3:0]  alu_ctrl;
    logic [1:0]  op1_sel;
    logic        op2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_write, mem_read, mem_write, branch, jump, jalr;
    logic [2:0]  mem_size;
    logic        illegal;

    exp_t act;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    rv_decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .alu_ctrl  (alu_ctrl),
        .op1_sel   (op1_sel),
        .op2_sel   (op2_sel),
        .imm       (imm),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .branch    (branch),
        .jump      (jump),
        .jalr      (jalr),
        .mem_size  (mem_size),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    assign act = {out_pc, alu_ctrl, op1_sel, op2_sel, imm, rs1_addr, rs2_addr, rd_addr,
                  reg_write, mem_read, mem_write, branch, jump, jalr, mem_size, illegal};

    // flags order: reg_write, mem_read, mem_write, branch, jump, jalr
    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] alu, input logic [1:0] op1,
                                input logic op2, input logic [31:0] im, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [5:0] flags,
                                input logic [2:0] msz, input logic ill);
        exp_t e;
        e = {pc, alu, op1, op2, im, rs1, rs2, rd, flags, msz, ill};
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (act !== '0) begin
            errors++; $display("[TB] FAIL reset_payload: got %h expected 0", act);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] tab_instr [18];
        exp_t        tab_exp [18];
        int          sent = 0;
        int          got = 0;
        logic        took = 1'b0;
        exp_t        e;
        tab_instr[0]  = 32'h002081B3; tab_exp[0]  = mk(0, 4'h0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  6'b100000, 3'd0, 1'b0);
        tab_instr[1]  = 32'h402081B3; tab_exp[1]  = mk(0, 4'h8, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  6'b100000, 3'd0, 1'b0);
        tab_instr[2]  = 32'h40335293; tab_exp[2]  = mk(0, 4'hD, 2'd0, 1'b1, 32'h3,        5'd6, 5'd3,  5'd5,  6'b100000, 3'd0, 1'b0);
        tab_instr[3]  = 32'h40000093; tab_exp[3]  = mk(0, 4'h0, 2'd0, 1'b1, 32'h400,      5'd0, 5'd0,  5'd1,  6'b100000, 3'd0, 1'b0);
        tab_instr[4]  = 32'h0020E463; tab_exp[4]  = mk(0, 4'h6, 2'd0, 1'b0, 32'h8,        5'd1, 5'd2,  5'd8,  6'b000100, 3'd0, 1'b0);
        tab_instr[5]  = 32'hFFF00093; tab_exp[5]  = mk(0, 4'h0, 2'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1,  6'b100000, 3'd0, 1'b0);
        tab_instr[6]  = 32'h00812283; tab_exp[6]  = mk(0, 4'h0, 2'd0, 1'b1, 32'h8,        5'd2, 5'd8,  5'd5,  6'b110000, 3'd2, 1'b0);
        tab_instr[7]  = 32'hFE612E23; tab_exp[7]  = mk(0, 4'h0, 2'd0, 1'b1, 32'hFFFFFFFC, 5'd2, 5'd6,  5'd28, 6'b001000, 3'd2, 1'b0);
        tab_instr[8]  = 32'h123453B7; tab_exp[8]  = mk(0, 4'h0, 2'd2, 1'b1, 32'h12345000, 5'd8, 5'd3,  5'd7,  6'b100000, 3'd0, 1'b0);
        tab_instr[9]  = 32'h00001117; tab_exp[9]  = mk(0, 4'h0, 2'd1, 1'b1, 32'h1000,     5'd0, 5'd0,  5'd2,  6'b100000, 3'd0, 1'b0);
        tab_instr[10] = 32'h010000EF; tab_exp[10] = mk(0, 4'h0, 2'd1, 1'b1, 32'h10,       5'd0, 5'd16, 5'd1,  6'b100010, 3'd0, 1'b0);
        tab_instr[11] = 32'h00008067; tab_exp[11] = mk(0, 4'h0, 2'd0, 1'b1, 32'h0,        5'd1, 5'd0,  5'd0,  6'b100011, 3'd0, 1'b0);
        tab_instr[12] = 32'h0000007F; tab_exp[12] = mk(0, 4'h0, 2'd0, 1'b0, 32'h0,        5'd0, 5'd0,  5'd0,  6'b000000, 3'd0, 1'b1);
        tab_instr[13] = 32'h022081B3; tab_exp[13] = mk(0, 4'h0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  6'b000000, 3'd0, 1'b1);
        tab_instr[14] = 32'h402091B3; tab_exp[14] = mk(0, 4'h0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  6'b000000, 3'd0, 1'b1);
        tab_instr[15] = 32'h40209093; tab_exp[15] = mk(0, 4'h0, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd1,  6'b000000, 3'd0, 1'b1);
        tab_instr[16] = 32'h00335293; tab_exp[16] = mk(0, 4'h5, 2'd0, 1'b1, 32'h3,        5'd6, 5'd3,  5'd5,  6'b100000, 3'd0, 1'b0);
        tab_instr[17] = 32'h4020D1B3; tab_exp[17] = mk(0, 4'hD, 2'd0, 1'b0, 32'h0,        5'd1, 5'd2,  5'd3,  6'b100000, 3'd0, 1'b0);
        for (int i = 0; i < 18; i++) tab_exp[i].pc = 32'h1000 + 32'(i) * 4;
        sb.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && (sent < 18 || got < 18); cyc++) begin
            #1;
            checks++;
            if (out_valid !== took) begin
                errors++; $display("[TB] FAIL decode_latency: got valid=%b expected %b at cycle %0d", out_valid, took, cyc);
            end
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got++;
                checks++;
                if (act !== e) begin
                    errors++; $display("[TB] FAIL decode_bundle pc=%h: got %h expected %h", e.pc, act, e);
                end
            end
            if (sent < 18) begin
                in_valid = 1'b1;
                in_instr = tab_instr[sent];
                in_pc    = 32'h1000 + 32'(sent) * 4;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            took = in_valid && in_ready;
            if (took) begin
                sb.push_back(tab_exp[sent]);
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (got != 18) begin
            errors++; $display("[TB] FAIL decode_count: got %0d bundles expected 18", got);
        end
    endtask

    task automatic test_back_to_back();
        exp_t ea;
        exp_t eb;
        exp_t e;
        logic took;
        logic exp_ready;
        int   got = 0;
        ea = mk(32'h200, 4'h0, 2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000, 3'd0, 1'b0);
        eb = mk(32'h204, 4'h8, 2'd0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b100000, 3'd0, 1'b0);
        sb.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        in_pc     = 32'h200;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_first_ready: got %b expected 1", in_ready);
        end
        took = in_ready;
        @(posedge clk);
        @(negedge clk);
        if (took) sb.push_back(ea);
        in_instr = 32'h402081B3;
        in_pc    = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || act !== ea) begin
                errors++; $display("[TB] FAIL stall_hold cycle %0d: got valid=%b %h expected valid=1 %h", c, out_valid, act, ea);
            end
`ifdef DECODE_SKID_EN
            exp_ready = (c == 0);
`else
            exp_ready = 1'b0;
`endif
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("[TB] FAIL stall_ready cycle %0d: got %b expected %b", c, in_ready, exp_ready);
            end
            took = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (took) begin
                sb.push_back(eb);
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && got < 2; c++) begin
            #1;
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                got++;
                checks++;
                if (act !== e) begin
                    errors++; $display("[TB] FAIL stall_order pc=%h: got %h expected %h", e.pc, act, e);
                end
            end
            took = in_valid && in_ready;
            @(posedge clk);
            @(negedge clk);
            if (took) begin
                sb.push_back(eb);
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 2) begin
            errors++; $display("[TB] FAIL stall_drain: got %0d bundles expected 2", got);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic took;
        sb.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3;
        in_pc     = 32'h300;
        flush     = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_same_cycle: got valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h402081B3;
        in_pc     = 32'h304;
        @(posedge clk);
        @(negedge clk);
        in_instr = 32'h40335293;
        in_pc    = 32'h308;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_pre_held: got valid=%b expected 1", out_valid);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL flush_held cycle %0d: got valid=%b ready=%b expected valid=0 ready=1", c, out_valid, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_instr = 32'h00001117;
        in_pc    = 32'h30C;
        #1;
        took = in_ready;
        if (took) sb.push_back(mk(32'h30C, 4'h0, 2'd1, 1'b1, 32'h1000, 5'd0, 5'd0, 5'd2, 6'b100000, 3'd0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("[TB] FAIL flush_recover_valid: got valid=%b queued=%0d expected valid=1 queued=1", out_valid, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if (act !== e) begin
                errors++; $display("[TB] FAIL flush_recover: got %h expected %h", act, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h123453B7;
        in_pc     = 32'h400;
        @(posedge clk);
        @(negedge clk);
        in_instr = 32'h002081B3;
        in_pc    = 32'h404;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pre_stall: got valid=%b expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || act !== '0) begin
            errors++; $display("[TB] FAIL rst_async: got valid=%b %h expected valid=0 payload 0", out_valid, act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_release: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
RV32I decode pipeline stage; the upstream counterpart of the ALU. Accepts fetched instructions over a valid/ready handshake and produces a registered control bundle: ALU control {funct7[5],funct3}, operand selects, immediate, register addresses and memory/branch flags. Sits between the fetch stage and the execute stage, with a flush input for branch redirects.

Parameters:
DATA_WIDTH, 32, instruction/PC/immediate width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  32  instruction address
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  32  registered in_pc
alu_ctrl  out  4  {funct7[5],funct3} in the ALU's encoding
op1_sel  out  2  0=rs1, 1=pc, 2=zero
op2_sel  out  1  0=rs2, 1=imm
imm  out  32  sign-extended immediate (I/S/B/U/J)
rs1_addr, rs2_addr, rd_addr  out  5 each  register fields
reg_write, mem_read, mem_write, branch, jump, jalr  out  1 each  control flags
mem_size  out  3  funct3 for loads/stores
illegal  out  1  unrecognised encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0; every payload output 0; no pending entry.
- Transfer in: in_valid&&in_ready. Transfer out: out_valid&&out_ready. Latency 1 cycle from accept to out_valid.
- Base mode: in_ready = !out_valid || out_ready (combinational); payload registers load only on transfer-in; outputs stable while out_valid&&!out_ready.
- flush=1: next cycle out_valid=0; instruction accepted that cycle discarded; in_ready unaffected. Flush beats a simultaneous transfer.
- alu_ctrl: R-type {funct7[5],funct3}; I-type ALU {funct3==101 ? funct7[5] : 0, funct3} (ADDI with imm[10]=1 must stay 0000); branches {0,funct3} (BEQ..BGEU map straight to ALU compare select); LOAD/STORE/LUI/AUIPC/JAL/JALR 0000.
- op1_sel: LUI=zero, AUIPC/JAL=pc, else rs1. op2_sel=imm for all except R-type and branch.
- reg_write=1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR; forced 0 when rd=0 is NOT done (regfile ignores x0).
- illegal: unknown opcode; R-type funct7 not 0x00/0x20; funct7=0x20 with funct3 not 000/101; SLLI/SRLI/SRAI with bad funct7. Illegal bundle: illegal=1, reg_write/mem_*/branch/jump=0, alu_ctrl=0000; still delivered with out_valid.

Optional Feature:
DECODE_SKID_EN defined: two-entry skid buffer; in_ready is a register (=!skid_full), no combinational in_ready<-out_ready path; skid fills when out stalls during a transfer-in, drains first; flush clears both entries. Undefined: single register, combinational in_ready as above. Latency 1 in both.

Decomposition:
- Package decode_pkg: opcode localparams, ALU_ADD/ALU_SUB/... 4-bit constants, op1_sel/op2_sel enums, packed struct decode_bundle_t.
- Sub-module imm_gen: combinational immediate extractor by format.

Test Plan:
- 0x002081B3 (ADD x3,x1,x2) -> alu_ctrl 0000, rs1 1, rs2 2, rd 3, op2_sel 0, reg_write 1; 0x402081B3 (SUB) -> 1000.
- 0x40335293 (SRAI x5,x6,3) -> alu_ctrl 1101, imm 3; 0x40000093 (ADDI x1,x0,1024) -> alu_ctrl 0000, imm 0x400.
- BLTU x1,x2 (funct3 110) -> alu_ctrl 0110, branch 1, reg_write 0, op2_sel 0; 0xFFF00093 -> imm 0xFFFFFFFF.
- out_ready=0 for 3 cycles after out_valid -> bundle stable, in_ready 0 (base) / accepts one more then 0 (skid); release -> order preserved.
- flush with in_valid same cycle -> out_valid 0 next cycle; opcode 0x0000007F -> illegal 1, all write flags 0.
- rst_n low mid-stall -> out_valid 0 immediately, payload 0, in_ready 1 after release.
